sr_latch_nand_reg: RTL and testbench

- Clocked, vectorised model of a NAND-based SR latch with active-high set/reset inputs; each input is internally inverted into the NAND pair.
- Per bit: set forces q high, reset forces q_not high, both asserted drives both outputs high, neither asserted holds state.
- Used as a registered status/flag element wherever the classic NAND-latch truth table is required synchronously.
- Adds per-bit conflict flags and a saturating conflict counter for diagnostics.

---
 rtl/sr_latch_nand_reg.sv | 88 ++++++++
 tb/tb_sr_latch_nand_reg.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sr_latch_nand_reg.sv
// Registered, vectorised NAND SR latch with active-high set/reset, per-bit
// conflict flags and a saturating overlap counter.

module sr_latch_nand_lane (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_not,
  output logic conflict
);
  logic s_n, r_n;
  logic q_d, q_q, qn_d, qn_q, cf_d, cf_q;

  // Classic cross-coupled NAND pair, with the feedback path broken by the
  // registers so each edge evaluates one settled step of the latch.
  always_comb begin
    s_n  = ~s;
    r_n  = ~r;
    q_d  = ~(s_n & ~(r_n & q_q));
    qn_d = ~(r_n & ~(s_n & qn_q));
    cf_d = s & r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= 1'b0;
      qn_q <= 1'b1;
      cf_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      qn_q <= qn_d;
      cf_q <= cf_d;
    end
  end

  assign q        = q_q;
  assign q_not    = qn_q;
  assign conflict = cf_q;
endmodule

module sr_latch_nand_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] reset,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic [WIDTH-1:0] conflict,
  output logic             any_conflict,
  output logic [CNT_W-1:0] conflict_cnt
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             overlap;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sr_latch_nand_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .s        (set[i]),
      .r        (reset[i]),
      .q        (q[i]),
      .q_not    (q_not[i]),
      .conflict (conflict[i])
    );
  end

  // Clear beats increment; the count sticks at all ones once reached.
  always_comb begin
    overlap = |(set & reset);
    cnt_d   = cnt_q;
    if (cnt_clr)                      cnt_d = '0;
    else if (overlap && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign any_conflict = |conflict;
  assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_sr_latch_nand_reg.sv
// Directed + random bench for sr_latch_nand_reg against a per-bit
// truth-table model with an integer saturating counter.

module tb_sr_latch_nand_reg;
  localparam int W     = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [W-1:0]     set = '0;
  logic [W-1:0]     reset = '0;
  logic             cnt_clr = 1'b0;
  logic [W-1:0]     q, q_not, conflict;
  logic             any_conflict;
  logic [CNT_W-1:0] conflict_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  bit m_q [W];
  bit m_qn[W];
  bit m_cf[W];
  int m_cnt;

  sr_latch_nand_reg #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .set          (set),
    .reset        (reset),
    .cnt_clr      (cnt_clr),
    .q            (q),
    .q_not        (q_not),
    .conflict     (conflict),
    .any_conflict (any_conflict),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input bit a[W]);
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic [W-1:0] s, input logic [W-1:0] rs,
                            input logic c);
    bool_any_t: begin end
    if (r) begin
      for (int i = 0; i < W; i++) begin m_q[i] = 0; m_qn[i] = 1; m_cf[i] = 0; end
      m_cnt = 0;
    end else begin
      int ov = 0;
      for (int i = 0; i < W; i++) begin
        case ({s[i], rs[i]})
          2'b00: ;
          2'b01: begin m_q[i] = 0; m_qn[i] = 1; end
          2'b10: begin m_q[i] = 1; m_qn[i] = 0; end
          2'b11: begin m_q[i] = 1; m_qn[i] = 1; ov = 1; end
        endcase
        m_cf[i] = s[i] & rs[i];
      end
      if (c)                       m_cnt = 0;
      else if (ov && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] s, input logic [W-1:0] rs,
                      input logic c, input string tag);
    logic [W-1:0] ecf;
    @(negedge clk);
    rst = r; set = s; reset = rs; cnt_clr = c;
    @(posedge clk);
    model_edge(r, s, rs, c);
    #1;
    ecf = pack(m_cf);
    chk({tag, ".q"},        32'(q),            32'(pack(m_q)));
    chk({tag, ".q_not"},    32'(q_not),        32'(pack(m_qn)));
    chk({tag, ".conflict"}, 32'(conflict),     32'(ecf));
    chk({tag, ".any"},      32'(any_conflict), 32'(|ecf));
    chk({tag, ".cnt"},      32'(conflict_cnt), 32'(m_cnt));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, '0, '0, 0, "rst0");
    step(1, '0, '0, 0, "rst1");
    // reset direction, then set direction
    step(0, '0, '1, 0, "rdir");
    step(0, '1, '0, 0, "sdir");
    for (int k = 0; k < 3; k++) step(0, '0, '0, 0, "hold1");
    step(0, '0, '1, 0, "rdir2");
    for (int k = 0; k < 3; k++) step(0, '0, '0, 0, "hold0");
    // forbidden state and hold of 1/1
    step(0, '1, '1, 0, "both");
    step(0, '0, '0, 0, "hold11");
    step(0, '0, '0, 0, "hold11b");
    // counter saturation, clear priority, mid-run reset
    for (int k = 0; k < 300; k++) step(0, 4'b0100, 4'b0100, 0, "sat");
    step(0, '1, '1, 1, "clr_ovl");
    step(0, '1, '1, 0, "post_clr");
    step(1, '1, '0, 0, "rst_mid");
    // mixed-bit vector from reset state
    step(0, 4'b0011, 4'b0110, 0, "mixed");
    chk("mixed.q_lit",  32'(q),        32'h3);
    chk("mixed.qn_lit", 32'(q_not),    32'hE);
    chk("mixed.cf_lit", 32'(conflict), 32'h2);
    // random traffic
    for (int k = 0; k < 500; k++) begin
      logic          r_r, r_c;
      logic [W-1:0]  r_s, r_rs;
      r_r  = ($urandom_range(0, 49) == 0);
      r_c  = ($urandom_range(0, 29) == 0);
      r_s  = W'($urandom);
      r_rs = W'($urandom);
      if (k >= 200 && k < 480) begin r_c = 1'b0; r_r = 1'b0; r_s[0] = 1'b1; r_rs[0] = 1'b1; end
      step(r_r, r_s, r_rs, r_c, "rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
